// File: rtl/tap_tick_pkg.sv
// rtl/tap_tick_pkg.sv - shared constants and FSM state type for the tap tick counter
package tap_tick_pkg;

  localparam int NTAPS       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int SEL_W       = $clog2(NTAPS);
  localparam int BLANK_CYC   = SYNC_STAGES + 1;
  localparam int BLANK_W     = $clog2(BLANK_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/tap_tick_counter_if.sv
// rtl/tap_tick_counter_if.sv - tap inputs, control and tick/count/hit outputs of the tap tick counter
interface tap_tick_if;
  import tap_tick_pkg::*;

  logic [NTAPS-1:0] taps;
  logic [SEL_W-1:0] tap_sel;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] thresh;
  logic             hit_ack;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             hit;
  logic             overrun;

  modport master (
    output taps, tap_sel, en, clr, thresh, hit_ack,
    input  tick, count, hit, overrun
  );

  modport slave (
    input  taps, tap_sel, en, clr, thresh, hit_ack,
    output tick, count, hit, overrun
  );

endinterface

// File: rtl/tap_sync_edge.sv
// rtl/tap_sync_edge.sv - synchroniser chain plus rising-edge detect for one asynchronous tap
module tap_sync_edge
  import tap_tick_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tap_tick_counter.sv
// rtl/tap_tick_counter.sv - selects a divider tap, ticks on its synchronised rising edges,
// counts ticks modulo thresh and raises sticky hit/overrun flags
module tap_tick_counter
  import tap_tick_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  tap_tick_if.slave bus
);

  state_t             state, state_nxt;
  logic [BLANK_W-1:0] blank_cnt, blank_nxt;
  logic [SEL_W-1:0]   sel_q;
  logic               sel_chg;
  logic               rise;
  logic               tick_evt;
  logic               tick_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_inc;
  logic               hit_q;
  logic               ovr_q;
  logic               hit_evt;

  // Mux uses the registered select so the chain always sees a stable source per cycle.
  tap_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.taps[sel_q]),
    .rise  (rise)
  );

  assign sel_chg   = (bus.tap_sel != sel_q);
  assign count_inc = count_q + 1'b1;
  assign hit_evt   = tick_evt & (count_inc == bus.thresh);

  always_comb begin
    state_nxt = state;
    blank_nxt = blank_cnt;
    tick_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_nxt = BLANK;
          blank_nxt = BLANK_W'(BLANK_CYC);
        end
      end
      BLANK: begin
        if (!bus.en) begin
          state_nxt = IDLE;
        end else if (sel_chg) begin
          blank_nxt = BLANK_W'(BLANK_CYC);
        end else if (blank_cnt == BLANK_W'(1)) begin
          state_nxt = RUN;
          blank_nxt = '0;
        end else begin
          blank_nxt = blank_cnt - 1'b1;
        end
      end
      RUN: begin
        tick_evt = rise;
        if (!bus.en) begin
          state_nxt = IDLE;
        end else if (sel_chg) begin
          state_nxt = BLANK;
          blank_nxt = BLANK_W'(BLANK_CYC);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blank_cnt <= '0;
      sel_q     <= '0;
      tick_q    <= 1'b0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_nxt;
      sel_q     <= bus.tap_sel;
      tick_q    <= tick_evt;
      // clr drops a coincident tick from the count but the tick output still pulses.
      if (bus.clr) begin
        count_q <= '0;
        hit_q   <= 1'b0;
        ovr_q   <= 1'b0;
      end else if (hit_evt) begin
        count_q <= '0;
        hit_q   <= 1'b1;
        if (hit_q && !bus.hit_ack) ovr_q <= 1'b1;
      end else begin
        if (tick_evt)    count_q <= count_inc;
        if (bus.hit_ack) hit_q   <= 1'b0;
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.count   = count_q;
  assign bus.hit     = hit_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_tap_tick_counter.sv
// tb/tb_tap_tick_counter.sv - randomized self-checking bench for tap_tick_counter against a tick/hit model
module tb_tap_tick_counter;
  import tap_tick_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cur_sel = 0;

  int   m_count = 0;
  bit   m_hit = 0;
  bit   m_ovr = 0;
  int   m_thresh = 0;

  int   n_tick;
  int   wide;
  bit   last_t;
  int   seen;
  int   phase;

  tap_tick_if bus();

  tap_tick_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one tick advances the count mod 256; reaching thresh (0 meaning 256) is a hit event.
  task automatic m_tick(input bit ack);
    int nxt;
    nxt = (m_count + 1) % 256;
    if (nxt == m_thresh) begin
      m_count = 0;
      if (m_hit && !ack) m_ovr = 1;
      m_hit = 1;
    end else begin
      m_count = nxt;
      if (ack) m_hit = 0;
    end
  endtask

  task automatic m_clr();
    m_count = 0;
    m_hit   = 0;
    m_ovr   = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},   32'(bus.count),   32'(m_count));
    check({tag, "_hit"},     32'(bus.hit),     32'(m_hit));
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
  endtask

  // One clean tap pulse; ack/clr are held in the cycle the synchronised edge is registered.
  task automatic do_tick(input string tag, input bit ack, input bit clr);
    int cnt;
    cnt = 0;
    @(negedge clk);
    bus.taps[cur_sel] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.hit_ack = ack; bus.clr = clr; end
      if (i == 2) begin bus.hit_ack = 1'b0; bus.clr = 1'b0; end
      if (i == 5) bus.taps[cur_sel] = 1'b0;
      if (bus.tick) cnt++;
    end
    if (clr) m_clr(); else m_tick(ack);
    check({tag, "_tick"}, 32'(cnt), 32'd1);
    check_state(tag);
  endtask

  task automatic ack_alone(input string tag);
    @(negedge clk); bus.hit_ack = 1'b1;
    @(negedge clk); bus.hit_ack = 1'b0;
    m_hit = 0;
    check_state(tag);
  endtask

  task automatic set_thresh(input int t);
    @(negedge clk);
    bus.thresh = 8'(t);
    m_thresh = t;
  endtask

  initial begin
    bus.taps = '0; bus.tap_sel = '0; bus.en = 1'b0; bus.clr = 1'b0;
    bus.thresh = '0; bus.hit_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tick", 32'(bus.tick), 32'd0);
    check_state("reset");
    rst_n = 1'b1;
    bus.en = 1'b1;
    repeat (6) @(negedge clk);

    // Reset mid-run with count=5 and hit=1.
    set_thresh(2);
    do_tick("pre_a", 0, 0);
    do_tick("pre_b", 0, 0);
    set_thresh(200);
    for (int k = 0; k < 5; k++) do_tick("pre_c", 0, 0);
    check("pre_rst_count", 32'(bus.count), 32'd5);
    check("pre_rst_hit", 32'(bus.hit), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_tick", 32'(bus.tick), 32'd0);
    check("rst_async_count", 32'(bus.count), 32'd0);
    check("rst_async_hit", 32'(bus.hit), 32'd0);
    check("rst_async_overrun", 32'(bus.overrun), 32'd0);
    m_clr();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.taps[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < BLANK_CYC + SYNC_STAGES; i++) begin
      @(negedge clk);
      if (bus.tick) seen++;
    end
    check("rst_latency", 32'(seen), 32'd0);
    bus.taps[0] = 1'b0;
    repeat (4) @(negedge clk);

    // thresh=4, ten ticks without ack.
    set_thresh(4);
    for (int k = 1; k <= 10; k++) do_tick($sformatf("t4_%0d", k), 0, 0);
    check("t4_final_count", 32'(bus.count), 32'd2);
    check("t4_final_overrun", 32'(bus.overrun), 32'd1);

    // thresh=3, ack coincident with the 6th tick, then ack alone.
    @(negedge clk); bus.clr = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
    m_clr();
    check_state("clr_alone");
    set_thresh(3);
    for (int k = 1; k <= 5; k++) do_tick($sformatf("t3_%0d", k), 0, 0);
    do_tick("t3_6_ack", 1, 0);
    check("t3_ack_hit", 32'(bus.hit), 32'd1);
    check("t3_ack_overrun", 32'(bus.overrun), 32'd0);
    ack_alone("t3_ack_only");
    check("t3_ack_only_hit", 32'(bus.hit), 32'd0);

    // Select change 0->5 with tap5 already high: blanked, no tick.
    do_tick("pre_sel", 0, 0);
    @(negedge clk); bus.taps[5] = 1'b1;
    @(negedge clk); bus.tap_sel = 3'd5; cur_sel = 5;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.tick) seen++;
    end
    check("sel_blank_tick", 32'(seen), 32'd0);
    check_state("sel_blank");
    bus.taps[5] = 1'b0;
    repeat (4) @(negedge clk);
    do_tick("sel_first", 0, 0);

    // thresh=0: one hit per 256 ticks, clr on the 257th.
    @(negedge clk); bus.clr = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
    m_clr();
    set_thresh(0);
    for (int k = 1; k <= 255; k++) begin
      do_tick("wrap", 0, 0);
      if (bus.hit) check("wrap_early_hit", 32'(bus.hit), 32'd0);
    end
    check("wrap_255_count", 32'(bus.count), 32'd255);
    do_tick("wrap_256", 0, 0);
    check("wrap_256_hit", 32'(bus.hit), 32'd1);
    do_tick("wrap_257_clr", 0, 1);

    // Randomized mix of ticks, acks, clears and threshold changes.
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)
        do_tick("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      else if (r < 9)
        ack_alone("rnd_ack");
      else
        set_thresh($urandom_range(0, 8));
    end

    // Tap toggling every clk at a phase unrelated to the clock edges.
    set_thresh(7);
    n_tick = 0; wide = 0; last_t = 1'b0;
    phase = $urandom_range(1, 4);
    fork
      begin
        @(negedge clk);
        #(phase);
        repeat (20) begin
          bus.taps[cur_sel] = 1'b1; #10;
          bus.taps[cur_sel] = 1'b0; #10;
        end
      end
      begin
        repeat (50) begin
          @(negedge clk);
          if (bus.tick) begin
            n_tick++;
            if (last_t) wide++;
          end
          last_t = bus.tick;
        end
      end
    join
    for (int k = 0; k < 20; k++) m_tick(0);
    check("toggle_tick_count", 32'(n_tick), 32'd20);
    check("toggle_tick_width", 32'(wide), 32'd0);
    check_state("toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
